// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Divisor clamping and half-period math live here so every stage agrees.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  function automatic int clamp_div(input int d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic int half_period(input int d);
    return d[0] ? (d - 1) / 2 : d / 2;
  endfunction

endpackage

// File: rtl/clk_div_neg_stage.sv
// Negedge retimer: half-cycle delayed copy of the posedge phase.
// Kept alone so the only falling-edge flop is easy to constrain.
module clk_div_neg_stage (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // sample the posedge phase on the falling edge
  always_ff @(negedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable 50% duty integer clock divider.
// Divisor changes and enable parking only take effect at period ends.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clkout,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] pend_val;
  logic [CNT_W-1:0] new_d;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] half_new;
  logic [CNT_W-1:0] load_d;
  logic             p_q;
  logic             n_q;
  logic             odd_q;
  logic             parked;
  logic             boundary;
  logic             start;

  assign cnt_inc  = cnt + ONE;
  assign boundary = !parked && (cnt == div_active - ONE);
  assign start    = en && (boundary || parked);
  assign new_d    = pend ? pend_val : div_active;
  assign half_act = CNT_W'(half_period(int'(div_active)));
  assign half_new = CNT_W'(half_period(int'(new_d)));
  assign load_d   = CNT_W'(clamp_div(int'(div_val)));

  // period counter, posedge phase, parking and divisor hand-over
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      p_q        <= 1'b0;
      tick       <= 1'b0;
      parked     <= 1'b0;
      div_active <= DEF_D;
      odd_q      <= DEF_D[0];
      pend       <= 1'b0;
      pend_val   <= DEF_D;
    end else begin
      if (start) begin
        cnt        <= '0;
        tick       <= 1'b1;
        p_q        <= (half_new != '0);
        parked     <= 1'b0;
        div_active <= new_d;
        odd_q      <= new_d[0];
      end else if (boundary || parked) begin
        cnt    <= '0;
        tick   <= 1'b0;
        p_q    <= 1'b0;
        parked <= 1'b1;
      end else begin
        cnt  <= cnt_inc;
        tick <= 1'b0;
        p_q  <= (cnt_inc < half_act);
      end
      if (div_load) begin
        pend     <= 1'b1;
        pend_val <= load_d;
      end else if (start) begin
        pend <= 1'b0;
      end
    end
  end

  clk_div_neg_stage u_neg (
    .clk (clk),
    .rst (rst),
    .d   (p_q),
    .q   (n_q)
  );

  assign clkout = odd_q ? (p_q | n_q) : p_q;

endmodule
